// File: rtl/hv_efuse_load_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hv_efuse_load_ctrl_if                                            |
// | Brief   : Request/done, eFuse macro and register-bank signals of the       |
// |           HV eFuse load responder, grouped with master/slave modports.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface hv_efuse_load_ctrl_if #(
    parameter int EFUSE_ADDR_W = 3,
    parameter int EFUSE_DATA_W = 8
);
    logic                    i_efuse_load_req;
    logic                    o_efuse_load_done;
    logic                    o_efuse_vld;
    logic                    o_efuse_chk_err;
    logic                    o_efuse_busy;
    logic [EFUSE_ADDR_W-1:0] o_efuse_addr;
    logic                    o_efuse_rden;
    logic [EFUSE_DATA_W-1:0] i_efuse_rdata;
    logic                    o_reg_efuse_wr_en;
    logic [EFUSE_ADDR_W-1:0] o_reg_efuse_wr_addr;
    logic [EFUSE_DATA_W-1:0] o_reg_efuse_wr_data;

    modport master (
        output i_efuse_load_req, i_efuse_rdata,
        input  o_efuse_load_done, o_efuse_vld, o_efuse_chk_err, o_efuse_busy,
        input  o_efuse_addr, o_efuse_rden,
        input  o_reg_efuse_wr_en, o_reg_efuse_wr_addr, o_reg_efuse_wr_data
    );

    modport slave (
        input  i_efuse_load_req, i_efuse_rdata,
        output o_efuse_load_done, o_efuse_vld, o_efuse_chk_err, o_efuse_busy,
        output o_efuse_addr, o_efuse_rden,
        output o_reg_efuse_wr_en, o_reg_efuse_wr_addr, o_reg_efuse_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/hv_efuse_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hv_efuse_load_ctrl                                               |
// | Brief   : Reads every eFuse word with programmed setup/strobe timing,      |
// |           copies it to the register bank and reports image validity.       |
// |           EFUSE_LOAD_CHKSUM_EN enables the XOR checksum / nonzero check.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hv_efuse_load_ctrl #(
    parameter int EFUSE_WORD_NUM = 8,
    parameter int EFUSE_ADDR_W   = 3,
    parameter int EFUSE_DATA_W   = 8,
    parameter int RD_SETUP_CYC   = 2,
    parameter int RD_PULSE_CYC   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    hv_efuse_load_ctrl_if.slave  bus
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_setup   = 3'd1;
    localparam logic [2:0] c_st_strobe  = 3'd2;
    localparam logic [2:0] c_st_capture = 3'd3;
    localparam logic [2:0] c_st_check   = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;

    localparam int c_cnt_max = (RD_SETUP_CYC > RD_PULSE_CYC) ? RD_SETUP_CYC : RD_PULSE_CYC;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0]      c_setup_last = c_cnt_w'(RD_SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0]      c_pulse_last = c_cnt_w'(RD_PULSE_CYC - 1);
    localparam logic [EFUSE_ADDR_W-1:0] c_last_addr  = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

    logic [2:0]              r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [EFUSE_ADDR_W-1:0] r_addr;
    logic                    r_rden;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_vld;
    logic                    r_wr_en;
    logic [EFUSE_ADDR_W-1:0] r_wr_addr;
    logic [EFUSE_DATA_W-1:0] r_wr_data;
    logic                    w_ok;

`ifdef EFUSE_LOAD_CHKSUM_EN
    logic [EFUSE_DATA_W-1:0] r_acc;
    logic [EFUSE_DATA_W-1:0] r_chk;
    logic                    r_nz;
    logic                    r_chk_err;

    assign w_ok                = (r_acc == r_chk) & r_nz;
    assign bus.o_efuse_chk_err = r_chk_err;
`else
    assign w_ok                = 1'b1;
    assign bus.o_efuse_chk_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_rden    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_vld     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
`ifdef EFUSE_LOAD_CHKSUM_EN
            r_acc     <= '0;
            r_chk     <= '0;
            r_nz      <= 1'b0;
            r_chk_err <= 1'b0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.i_efuse_load_req) begin
                        r_state <= c_st_setup;
                        r_cnt   <= '0;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_vld   <= 1'b0;
`ifdef EFUSE_LOAD_CHKSUM_EN
                        r_chk_err <= 1'b0;
                        r_acc     <= '0;
                        r_nz      <= 1'b0;
`endif
                    end
                end
                c_st_setup: begin
                    if (r_cnt == c_setup_last) begin
                        r_cnt   <= '0;
                        r_rden  <= 1'b1;
                        r_state <= c_st_strobe;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_strobe: begin
                    // Macro data is only guaranteed while the strobe is high,
                    // so the word is latched on the last strobe cycle.
                    if (r_cnt == c_pulse_last) begin
                        r_cnt     <= '0;
                        r_rden    <= 1'b0;
                        r_wr_data <= bus.i_efuse_rdata;
                        r_state   <= c_st_capture;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_capture: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_addr;
`ifdef EFUSE_LOAD_CHKSUM_EN
                    if (r_addr == c_last_addr) begin
                        r_chk <= r_wr_data;
                    end else begin
                        r_acc <= r_acc ^ r_wr_data;
                    end
                    r_nz <= r_nz | (|r_wr_data);
`endif
                    if (r_addr == c_last_addr) begin
                        r_state <= c_st_check;
                    end else begin
                        r_addr  <= r_addr + EFUSE_ADDR_W'(1);
                        r_state <= c_st_setup;
                    end
                end
                c_st_check: begin
                    // Result registers load here so they are visible in DONE.
                    r_done  <= 1'b1;
                    r_vld   <= w_ok;
`ifdef EFUSE_LOAD_CHKSUM_EN
                    r_chk_err <= ~w_ok;
`endif
                    r_state <= c_st_done;
                end
                c_st_done: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_rden  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.o_efuse_load_done   = r_done;
    assign bus.o_efuse_vld         = r_vld;
    assign bus.o_efuse_busy        = r_busy;
    assign bus.o_efuse_addr        = r_addr;
    assign bus.o_efuse_rden        = r_rden;
    assign bus.o_reg_efuse_wr_en   = r_wr_en;
    assign bus.o_reg_efuse_wr_addr = r_wr_addr;
    assign bus.o_reg_efuse_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_hv_efuse_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_hv_efuse_load_ctrl                                            |
// | Brief   : Self-checking bench: table, random and timing/reset sequences.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hv_efuse_load_ctrl;

`ifdef EFUSE_LOAD_CHKSUM_EN
    localparam bit c_ck = 1'b1;
`else
    localparam bit c_ck = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] img;
        logic        exp_vld;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [63:0] img_a = '0;
    logic [63:0] img_b = '0;
    logic [7:0]  junk = 8'h5A;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(negedge clk) junk = 8'($urandom);

    hv_efuse_load_ctrl_if #(.EFUSE_ADDR_W(3), .EFUSE_DATA_W(8)) if_a ();
    hv_efuse_load_ctrl_if #(.EFUSE_ADDR_W(3), .EFUSE_DATA_W(8)) if_b ();

    hv_efuse_load_ctrl #(.EFUSE_WORD_NUM(8), .EFUSE_ADDR_W(3), .EFUSE_DATA_W(8),
                         .RD_SETUP_CYC(2), .RD_PULSE_CYC(4))
        dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(if_a));

    hv_efuse_load_ctrl #(.EFUSE_WORD_NUM(8), .EFUSE_ADDR_W(3), .EFUSE_DATA_W(8),
                         .RD_SETUP_CYC(3), .RD_PULSE_CYC(2))
        dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(if_b));

    function automatic logic [7:0] wsel(input logic [63:0] v, input int k);
        return v[k*8 +: 8];
    endfunction

    // eFuse macro model: data only meaningful while the strobe is high.
    assign if_a.i_efuse_rdata = if_a.o_efuse_rden ? wsel(img_a, int'(if_a.o_efuse_addr)) : junk;
    assign if_b.i_efuse_rdata = if_b.o_efuse_rden ? wsel(img_b, int'(if_b.o_efuse_addr)) : ~junk;

    // Reference: XOR of data words must equal the last word and the image must not be blank.
    function automatic logic model_vld(input logic [63:0] v);
        logic [7:0] x = 8'h00;
        for (int k = 0; k < 7; k++) x = x ^ wsel(v, k);
        if (!c_ck) return 1'b1;
        return (x == wsel(v, 7)) && (v != 64'h0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_done"},  {31'b0, if_a.o_efuse_load_done}, 0);
        chk({nm, "_vld"},   {31'b0, if_a.o_efuse_vld}, 0);
        chk({nm, "_err"},   {31'b0, if_a.o_efuse_chk_err}, 0);
        chk({nm, "_busy"},  {31'b0, if_a.o_efuse_busy}, 0);
        chk({nm, "_addr"},  {29'b0, if_a.o_efuse_addr}, 0);
        chk({nm, "_rden"},  {31'b0, if_a.o_efuse_rden}, 0);
        chk({nm, "_wren"},  {31'b0, if_a.o_reg_efuse_wr_en}, 0);
        chk({nm, "_wdata"}, {24'b0, if_a.o_reg_efuse_wr_data}, 0);
    endtask

    task automatic run_load(input int sel, input logic [63:0] img, input int drop_at,
                            input int exp_done, input logic exp_vld, input logic exp_err,
                            input string tag);
        int cyc = 0;
        int nwr = 0;
        int done_cyc = -1;
        int run = 0;
        int stable = 0;
        logic [2:0] pa = 3'd0;
        logic s_done, s_wen, s_rden, s_vld, s_err, s_busy;
        logic [2:0] s_wa, s_addr;
        logic [7:0] s_wd;
        if (sel == 0) begin img_a = img; if_a.i_efuse_load_req = 1'b1; end
        else          begin img_b = img; if_b.i_efuse_load_req = 1'b1; end
        s_vld = 1'b0; s_err = 1'b0; s_busy = 1'b0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (sel == 0) begin
                s_done = if_a.o_efuse_load_done; s_wen = if_a.o_reg_efuse_wr_en;
                s_wa = if_a.o_reg_efuse_wr_addr; s_wd = if_a.o_reg_efuse_wr_data;
                s_rden = if_a.o_efuse_rden; s_addr = if_a.o_efuse_addr;
                s_vld = if_a.o_efuse_vld; s_err = if_a.o_efuse_chk_err; s_busy = if_a.o_efuse_busy;
            end else begin
                s_done = if_b.o_efuse_load_done; s_wen = if_b.o_reg_efuse_wr_en;
                s_wa = if_b.o_reg_efuse_wr_addr; s_wd = if_b.o_reg_efuse_wr_data;
                s_rden = if_b.o_efuse_rden; s_addr = if_b.o_efuse_addr;
                s_vld = if_b.o_efuse_vld; s_err = if_b.o_efuse_chk_err; s_busy = if_b.o_efuse_busy;
            end
            if (cyc == drop_at) begin
                if (sel == 0) if_a.i_efuse_load_req = 1'b0;
                else          if_b.i_efuse_load_req = 1'b0;
            end
            if (s_wen) begin
                chk({tag, "_wr_addr"}, {29'b0, s_wa}, nwr);
                chk({tag, "_wr_data"}, {24'b0, s_wd}, {24'b0, wsel(img, nwr & 7)});
                nwr++;
            end
            if (sel == 1) begin
                if (!s_rden) begin
                    if (run > 0) chk({tag, "_pulse_len"}, run, 2);
                    run = 0;
                    stable = (s_addr == pa) ? stable + 1 : 1;
                end else begin
                    if (run == 0) chk({tag, "_addr_setup"}, (stable >= 3) ? 1 : 0, 1);
                    run++;
                    stable = 0;
                end
                pa = s_addr;
            end
            if (s_done) begin
                done_cyc = cyc;
                if (sel == 0) if_a.i_efuse_load_req = 1'b0;
                else          if_b.i_efuse_load_req = 1'b0;
                break;
            end
        end
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_num_writes"}, nwr, 8);
        chk({tag, "_vld"}, {31'b0, s_vld}, {31'b0, exp_vld});
        chk({tag, "_chk_err"}, {31'b0, s_err}, {31'b0, exp_err});
        chk({tag, "_busy_at_done"}, {31'b0, s_busy}, 1);
        @(negedge clk);
        if (sel == 0) begin
            chk({tag, "_done_pulse"}, {31'b0, if_a.o_efuse_load_done}, 0);
            chk({tag, "_busy_after"}, {31'b0, if_a.o_efuse_busy}, 0);
            chk({tag, "_vld_hold"}, {31'b0, if_a.o_efuse_vld}, {31'b0, exp_vld});
        end else begin
            chk({tag, "_done_pulse"}, {31'b0, if_b.o_efuse_load_done}, 0);
            chk({tag, "_busy_after"}, {31'b0, if_b.o_efuse_busy}, 0);
        end
        if (done_cyc < 0) begin
            if (sel == 0) if_a.i_efuse_load_req = 1'b0;
            else          if_b.i_efuse_load_req = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    localparam logic [63:0] c_valid   = 64'h00_77_66_55_44_33_22_11;
    localparam logic [63:0] c_corrupt = 64'h01_77_66_55_44_33_22_11;

    vec_t vecs [3];

    initial begin
        logic [63:0] rimg;
        logic [7:0]  x;
        if_a.i_efuse_load_req = 1'b0;
        if_b.i_efuse_load_req = 1'b0;
        vecs[0] = '{img: c_valid,   exp_vld: 1'b1,  exp_err: 1'b0};
        vecs[1] = '{img: c_corrupt, exp_vld: ~c_ck, exp_err: c_ck};
        vecs[2] = '{img: 64'h0,     exp_vld: ~c_ck, exp_err: c_ck};

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        for (int i = 0; i < 3; i++)
            run_load(0, vecs[i].img, 0, 58, vecs[i].exp_vld, vecs[i].exp_err, $sformatf("tbl%0d", i));

        run_load(0, c_valid, 10, 58, 1'b1, 1'b0, "req_drop");

        for (int r = 0; r < 6; r++) begin
            rimg = {$urandom, $urandom};
            if (r == 5) rimg = {8'h00, rimg[55:0]};
            x = 8'h00;
            for (int k = 0; k < 7; k++) x = x ^ wsel(rimg, k);
            if (r % 2 == 0) rimg[63:56] = x;
            run_load(0, rimg, 0, 58, model_vld(rimg), c_ck & ~model_vld(rimg), $sformatf("rnd%0d", r));
        end

        run_load(1, c_valid, 0, 50, 1'b1, 1'b0, "strobe_b");

        // Reset in the middle of a load.
        img_a = c_corrupt;
        if_a.i_efuse_load_req = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midload_rst");
        if_a.i_efuse_load_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", {31'b0, if_a.o_efuse_load_done}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_busy", {31'b0, if_a.o_efuse_busy}, 0);
        run_load(0, c_valid, 0, 58, 1'b1, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
